// File: rtl/dac_pattern_player.sv
// Pattern-RAM player feeding an AXI4-Stream DAC port; `define SYSREF_ALIGN_EN aligns start and wraps to sync_in.
// Latency: first beat 2 cycles after start (3 cycles after the sync_in edge when aligned); 1 beat/cycle sustained.
// Backpressure: 2-entry output buffer; RAM reads stall when it is full; outputs hold while tready is low.
module dac_pattern_player #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]  last_addr,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  sync_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

`ifdef SYSREF_ALIGN_EN
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_PLAY, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;
`endif

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  rd_en, rd_last, latch, issue;
  logic [ADDR_BITS-1:0]  rd_addr, rd_ptr, rd_ptr_nxt, last_q, cur_last;
  logic                  loop_q, cur_loop, stop_pending, stop_eff;
  logic                  inflight, inflight_last;
  logic [DATA_WIDTH-1:0] head_dat, skid_dat;
  logic                  head_vld, head_last, skid_vld, skid_last;
  logic                  pop, space;
  logic [1:0]            occ;

`ifdef SYSREF_ALIGN_EN
  logic sync_d, sync_rise, wrap_wait, wrap_wait_nxt;
  assign sync_rise = sync_in & ~sync_d;
`else
  logic unused_sync;
  assign unused_sync = sync_in;
`endif

  // Read-first: a same-address write this cycle is not visible to the read.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_addr];
  end

  assign pop      = head_vld & m_axis_tready;
  assign occ      = {1'b0, head_vld} + {1'b0, skid_vld} + {1'b0, inflight};
  assign space    = (occ != 2'd2) || pop;
  assign stop_eff = stop_pending | stop;

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    rd_addr    = rd_ptr;
    rd_ptr_nxt = rd_ptr;
    cur_last   = last_q;
    cur_loop   = loop_q;
    latch      = 1'b0;
    done       = 1'b0;
`ifdef SYSREF_ALIGN_EN
    wrap_wait_nxt = wrap_wait;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          latch      = 1'b1;
          rd_ptr_nxt = '0;
`ifdef SYSREF_ALIGN_EN
          state_nxt  = S_ARM;
`else
          // First read goes out in the start cycle itself to meet the 2-cycle latency.
          issue      = 1'b1;
          rd_addr    = '0;
          cur_last   = last_addr;
          cur_loop   = loop;
          state_nxt  = S_PLAY;
`endif
        end
      end
`ifdef SYSREF_ALIGN_EN
      S_ARM: begin
        if (stop) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (sync_rise) begin
          state_nxt = S_PLAY;
        end
      end
`endif
      S_PLAY: begin
`ifdef SYSREF_ALIGN_EN
        // A finished pass waiting for SYSREF can end right here on stop.
        if (wrap_wait) begin
          if (stop_eff) state_nxt = S_DRAIN;
          else if (sync_rise) wrap_wait_nxt = 1'b0;
        end else
`endif
        if (space) issue = 1'b1;
      end
      S_DRAIN: begin
        if (occ == 2'd0) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    rd_en   = issue;
    rd_last = issue && (rd_addr == cur_last);
    if (issue) begin
      if (rd_addr == cur_last) begin
        if (cur_loop && !stop_eff) begin
          rd_ptr_nxt = '0;
`ifdef SYSREF_ALIGN_EN
          wrap_wait_nxt = 1'b1;
`endif
        end else begin
          state_nxt = S_DRAIN;
        end
      end else begin
        rd_ptr_nxt = rd_addr + ADDR_BITS'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      rd_ptr        <= '0;
      last_q        <= '0;
      loop_q        <= 1'b0;
      stop_pending  <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
`ifdef SYSREF_ALIGN_EN
      sync_d        <= 1'b0;
      wrap_wait     <= 1'b0;
`endif
    end else begin
      state         <= state_nxt;
      rd_ptr        <= rd_ptr_nxt;
      inflight      <= rd_en;
      inflight_last <= rd_last;
      if (latch) begin
        last_q <= last_addr;
        loop_q <= loop;
      end
      if (done)                  stop_pending <= 1'b0;
      else if (state == S_IDLE)  stop_pending <= start & stop;
      else if (stop && state != S_DRAIN) stop_pending <= 1'b1;
`ifdef SYSREF_ALIGN_EN
      sync_d    <= sync_in;
      wrap_wait <= (state_nxt == S_IDLE) ? 1'b0 : wrap_wait_nxt;
`endif
    end
  end

  // Head register drives the stream; skid catches the in-flight beat during a stall.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_dat  <= '0;
      head_last <= 1'b0;
      head_vld  <= 1'b0;
      skid_dat  <= '0;
      skid_last <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (inflight && pop) begin
      if (skid_vld) begin
        head_dat  <= skid_dat;
        head_last <= skid_last;
        skid_dat  <= ram_q;
        skid_last <= inflight_last;
      end else begin
        head_dat  <= ram_q;
        head_last <= inflight_last;
      end
    end else if (inflight) begin
      if (!head_vld) begin
        head_dat  <= ram_q;
        head_last <= inflight_last;
        head_vld  <= 1'b1;
      end else begin
        skid_dat  <= ram_q;
        skid_last <= inflight_last;
        skid_vld  <= 1'b1;
      end
    end else if (pop) begin
      if (skid_vld) begin
        head_dat  <= skid_dat;
        head_last <= skid_last;
        skid_vld  <= 1'b0;
      end else begin
        head_vld  <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = head_dat;
  assign m_axis_tvalid = head_vld;
  assign m_axis_tlast  = head_vld & head_last;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_dac_pattern_player.sv
// Bench for dac_pattern_player: behavioural pattern model, per-beat scoreboard, stall-hold and latency checks.
module tb_dac_pattern_player;
  localparam int DW    = 128;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b1;
  logic          wr_en = 1'b0;
  logic [AB-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AB-1:0] last_addr = '0;
  logic          loop = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          sync_in = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          busy, done, m_axis_tvalid, m_axis_tlast;
  logic [DW-1:0] m_axis_tdata;

  dac_pattern_player #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_addr(last_addr), .loop(loop), .start(start), .stop(stop), .sync_in(sync_in),
    .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_dat_q [$];
  logic          exp_last_q [$];
  int beats_seen = 0;
  int rdy_mode = 0;
  int rdy_phase = 0;

  task automatic check_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every accepted beat against the model queue, plus hold-while-stalled.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] dat_prev = '0;
  logic          last_prev = 1'b0;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_prev) begin
        check_bit("hold_vld", m_axis_tvalid, 1'b1);
        check_dat("hold_dat", m_axis_tdata, dat_prev);
        check_bit("hold_last", m_axis_tlast, last_prev);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats_seen++;
        if (exp_dat_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat: got beat %h, expected no beat", m_axis_tdata);
        end else begin
          check_dat("beat_dat", m_axis_tdata, exp_dat_q.pop_front());
          check_bit("beat_last", m_axis_tlast, exp_last_q.pop_front());
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      dat_prev   = m_axis_tdata;
      last_prev  = m_axis_tlast;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: begin m_axis_tready = (rdy_phase % 3 == 0); rdy_phase++; end
      default: m_axis_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic ram_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AB'(a); wr_data = d; model_mem[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Beat i of a run is pattern entry i mod (last+1); tlast marks entry last.
  task automatic expect_beats(input int last, input int n);
    for (int i = 0; i < n; i++) begin
      exp_dat_q.push_back(model_mem[i % (last + 1)]);
      exp_last_q.push_back((i % (last + 1)) == last);
    end
  endtask

  task automatic flush_model();
    exp_dat_q.delete();
    exp_last_q.delete();
  endtask

  // Looping runs need tready=1: the read in cycle s is beat s, and the pass holding it completes.
  task automatic play(input int last, input bit lp, input bit stop_same, input int stop_at, input int extra_start_at);
    int n;
    int done_cyc;
    bit got;
    n = (!lp || stop_same) ? last + 1 : (stop_at / (last + 1) + 1) * (last + 1);
    expect_beats(last, n);
    beats_seen = 0;
    got = 1'b0;
    done_cyc = -1;
    last_addr = AB'(last); loop = lp; start = 1'b1; stop = stop_same;
    for (int c = 0; c < 20000; c++) begin
      @(negedge aclk);
      if (done) begin got = 1'b1; done_cyc = c; break; end
      tick();
      start = (c + 1 == extra_start_at);
      stop  = (c + 1 == stop_at);
    end
    tick();
    start = 1'b0; stop = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done pulse, expected one after %0d beats", n);
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
    end else begin
      check_int("beat_count", beats_seen, n);
      check_int("leftover_beats", exp_dat_q.size(), 0);
      if (rdy_mode == 0) check_int("done_cycle", done_cyc, n + 2);
      @(negedge aclk);
      check_bit("busy_after", busy, 1'b0);
      check_bit("done_after", done, 1'b0);
      tick();
    end
    flush_model();
  endtask

  initial begin
    #2 aresetn = 1'b0;
    #1;
    check_bit("rst_vld", m_axis_tvalid, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    repeat (3) tick();
    aresetn = 1'b1;
    @(negedge aclk);
    check_dat("rst_tdata", m_axis_tdata, '0);
    check_bit("rst_tlast", m_axis_tlast, 1'b0);
    tick();

    for (int k = 0; k < 4; k++) ram_write(k, {8{16'(k)}});
    rdy_mode = 0;
    tick();

`ifdef SYSREF_ALIGN_EN
    // Aligned start: sync_in rises in cycle 10, beat 0 must show in cycle 13.
    expect_beats(3, 4);
    beats_seen = 0;
    last_addr = AB'(3); loop = 1'b0; start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      if (c < 13) check_bit("arm_no_vld", m_axis_tvalid, 1'b0);
      if (c == 13) check_bit("arm_first_vld", m_axis_tvalid, 1'b1);
      if (done) break;
      tick();
      start = 1'b0;
      sync_in = (c + 1 >= 10) && (c + 1 < 14);
    end
    tick();
    sync_in = 1'b0;
    check_int("arm_beat_count", beats_seen, 4);
    check_int("arm_leftover", exp_dat_q.size(), 0);
    flush_model();

    // Stop while armed: done in the stop cycle, nothing sent.
    beats_seen = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    stop = 1'b1;
    @(negedge aclk);
    check_bit("arm_stop_done", done, 1'b1);
    tick();
    stop = 1'b0;
    @(negedge aclk);
    check_bit("arm_stop_busy", busy, 1'b0);
    check_int("arm_stop_beats", beats_seen, 0);
    tick();
`else
    // Directed 4-beat run with hand-computed values and timing.
    expect_beats(3, 4);
    beats_seen = 0;
    last_addr = AB'(3); loop = 1'b0; start = 1'b1;
    @(negedge aclk);
    check_bit("c0_vld", m_axis_tvalid, 1'b0);
    tick();
    start = 1'b0;
    @(negedge aclk);
    check_bit("c1_vld", m_axis_tvalid, 1'b0);
    check_bit("c1_busy", busy, 1'b1);
    @(negedge aclk);
    check_bit("c2_vld", m_axis_tvalid, 1'b1);
    check_dat("c2_dat", m_axis_tdata, {8{16'h0000}});
    check_bit("c2_last", m_axis_tlast, 1'b0);
    @(negedge aclk);
    check_dat("c3_dat", m_axis_tdata, {8{16'h0001}});
    @(negedge aclk);
    check_dat("c4_dat", m_axis_tdata, {8{16'h0002}});
    check_bit("c4_last", m_axis_tlast, 1'b0);
    @(negedge aclk);
    check_dat("c5_dat", m_axis_tdata, {8{16'h0003}});
    check_bit("c5_last", m_axis_tlast, 1'b1);
    @(negedge aclk);
    check_bit("c6_done", done, 1'b1);
    check_bit("c6_vld", m_axis_tvalid, 1'b0);
    @(negedge aclk);
    check_bit("c7_done", done, 1'b0);
    check_bit("c7_busy", busy, 1'b0);
    check_int("c7_beats", beats_seen, 4);
    tick();
    flush_model();

    rdy_mode = 1; rdy_phase = 0;
    play(3, 1'b0, 1'b0, -1, -1);
    rdy_mode = 0;
    play(2, 1'b1, 1'b0, 4, -1);
    play(1, 1'b1, 1'b1, -1, 3);
    play(0, 1'b1, 1'b0, 5, -1);

    for (int a = 0; a < 32; a++) ram_write(a, rand_beat());
    for (int it = 0; it < 10; it++) begin
      int last;
      bit lp;
      last = $urandom_range(0, 31);
      lp = ($urandom_range(0, 1) == 1);
      rdy_mode = lp ? 0 : $urandom_range(0, 2);
      rdy_phase = 0;
      play(last, lp, ($urandom_range(0, 3) == 0), lp ? $urandom_range(1, 3 * (last + 1)) : -1, $urandom_range(2, 6));
    end

    for (int a = 0; a < DEPTH; a++) ram_write(a, rand_beat());
    rdy_mode = 2;
    play(DEPTH - 1, 1'b0, 1'b0, -1, -1);

    // Reset in mid-run, then replay from beat 0 with the RAM untouched.
    rdy_mode = 0;
    tick();
    expect_beats(7, 8);
    last_addr = AB'(7); loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check_bit("mid_rst_vld", m_axis_tvalid, 1'b0);
    check_bit("mid_rst_busy", busy, 1'b0);
    check_bit("mid_rst_done", done, 1'b0);
    flush_model();
    tick();
    aresetn = 1'b1;
    tick();
    play(7, 1'b0, 1'b0, -1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
